// File: rtl/jt7759_rom_bridge.sv
// jt7759_rom_bridge: byte-wide ROM port for the jt7759 ADPCM core, served
// from a shared 16-bit memory channel (req/ack + data strobe). A 4-byte line
// cache absorbs sequential nibble fetches so only misses reach memory.
// Optional macro JT7759_ROM_PREFETCH_EN adds a second line and a next-line
// prefetch after every demand fill.
module jt7759_rom_bridge #(
  parameter int AW = 17,
  parameter int MW = 22,
  parameter logic [MW-1:0] BASE = 22'h0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  input  logic          rom_cs,
  input  logic [AW-1:0] rom_addr,
  output logic [7:0]    rom_data,
  output logic          rom_ok,
  output logic          mem_req,
  output logic [MW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic          mem_dst,
  input  logic [15:0]   mem_data
);

  localparam int TW = AW - 2;
`ifdef JT7759_ROM_PREFETCH_EN
  localparam int NL = 2;
`else
  localparam int NL = 1;
`endif

  typedef enum logic [1:0] {IDLE, REQ, RD0, RD1} state_t;

  state_t          state_reg, state_next;
  logic [TW-1:0]   tag_reg   [NL];
  logic [31:0]     line_reg  [NL];
  logic            valid_reg [NL];
  logic [NL-1:0]   line_hit;
  logic [TW-1:0]   cur_tag;
  logic [TW-1:0]   ftag_reg;
  logic [15:0]     word0_reg;
  logic            poison_reg;
  logic            fill_sel_reg;
  logic            victim;
  logic            hit;
  logic [31:0]     hit_word;
  logic [7:0]      hit_byte;
  logic            ok_q;
  logic [AW-1:0]   addr_q;
  logic            start_fetch, start_pf, cap0, fill_done;
`ifdef JT7759_ROM_PREFETCH_EN
  logic            mru_reg;
  logic            pf_reg;
  logic            hit_idx;
`endif

  // Memory word address of the first word of a line, wrapping modulo 2^MW.
  function automatic logic [MW-1:0] line_addr(input logic [TW-1:0] t);
    return BASE + MW'({t, 1'b0});
  endfunction

  assign cur_tag = rom_addr[AW-1:2];

  genvar gi;
  generate
    for (gi = 0; gi < NL; gi++) begin : g_line
      assign line_hit[gi] = valid_reg[gi] && (tag_reg[gi] == cur_tag);

      // Line storage: invalidate on fetch start, fill on the last strobe, clear on flush.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          valid_reg[gi] <= 1'b0;
          tag_reg[gi]   <= '0;
          line_reg[gi]  <= '0;
        end else begin
          if (start_fetch && (victim == 1'(gi)))
            valid_reg[gi] <= 1'b0;
          if (start_pf && (fill_sel_reg != 1'(gi)))
            valid_reg[gi] <= 1'b0;
          if (fill_done && (fill_sel_reg == 1'(gi))) begin
            line_reg[gi]  <= {mem_data, word0_reg};
            tag_reg[gi]   <= ftag_reg;
            valid_reg[gi] <= !(poison_reg || flush);
          end
          if (flush)
            valid_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // A flush in the same cycle suppresses the hit so stale data is never served.
  assign hit = rom_cs && (|line_hit) && !flush;

  // Select the hitting line and the addressed byte (little-endian in the line).
  always_comb begin
    hit_word = line_reg[0];
    for (int i = 0; i < NL; i++)
      if (line_hit[i]) hit_word = line_reg[i];
    hit_byte = hit_word[{rom_addr[1:0], 3'b000} +: 8];
  end

`ifdef JT7759_ROM_PREFETCH_EN
  // Index of the hitting line, used for replacement tracking.
  always_comb begin
    hit_idx = 1'b0;
    for (int i = 0; i < NL; i++)
      if (line_hit[i]) hit_idx = 1'(i);
  end

  // Most-recently-used line; demand misses replace the other one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      mru_reg <= 1'b0;
    else if (fill_done && !pf_reg)
      mru_reg <= fill_sel_reg;
    else if (hit)
      mru_reg <= hit_idx;
  end

  assign victim = ~mru_reg;
`else
  assign victim = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // FSM next state and one-cycle control strobes.
  always_comb begin
    state_next  = state_reg;
    start_fetch = 1'b0;
    start_pf    = 1'b0;
    cap0        = 1'b0;
    fill_done   = 1'b0;
    case (state_reg)
      IDLE: if (rom_cs && !hit) begin
        state_next  = REQ;
        start_fetch = 1'b1;
      end
      REQ: if (mem_ack) state_next = RD0;
      RD0: if (mem_dst) begin
        state_next = RD1;
        cap0       = 1'b1;
      end
      RD1: if (mem_dst) begin
        fill_done  = 1'b1;
        state_next = IDLE;
`ifdef JT7759_ROM_PREFETCH_EN
        if (!pf_reg && !poison_reg && !flush) begin
          state_next = REQ;
          start_pf   = 1'b1;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // Memory request side: address/request launch, ack handling, poison tracking.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      ftag_reg     <= '0;
      poison_reg   <= 1'b0;
      fill_sel_reg <= 1'b0;
      word0_reg    <= '0;
`ifdef JT7759_ROM_PREFETCH_EN
      pf_reg       <= 1'b0;
`endif
    end else begin
      if (start_fetch) begin
        ftag_reg     <= cur_tag;
        mem_addr     <= line_addr(cur_tag);
        mem_req      <= 1'b1;
        poison_reg   <= 1'b0;
        fill_sel_reg <= victim;
`ifdef JT7759_ROM_PREFETCH_EN
        pf_reg       <= 1'b0;
`endif
      end else if (start_pf) begin
        ftag_reg     <= ftag_reg + 1'b1;
        mem_addr     <= line_addr(ftag_reg + 1'b1);
        mem_req      <= 1'b1;
        poison_reg   <= 1'b0;
        fill_sel_reg <= ~fill_sel_reg;
`ifdef JT7759_ROM_PREFETCH_EN
        pf_reg       <= 1'b1;
`endif
      end else begin
        if (state_reg == REQ && mem_ack)
          mem_req <= 1'b0;
        if (flush && state_reg != IDLE)
          poison_reg <= 1'b1;
      end
      if (cap0)
        word0_reg <= mem_data;
    end
  end

  // Hit path: register the byte and the address it belongs to.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rom_data <= '0;
      addr_q   <= '0;
      ok_q     <= 1'b0;
    end else if (hit) begin
      rom_data <= hit_byte;
      addr_q   <= rom_addr;
      ok_q     <= 1'b1;
    end else begin
      ok_q     <= 1'b0;
    end
  end

  assign rom_ok = ok_q && rom_cs && (rom_addr == addr_q);

endmodule

// File: doc/jt7759_rom_bridge.md
Name: jt7759_rom_bridge

Overview:
- Upstream ROM adapter for the jt7759 ADPCM core.
- Serves the core's byte-wide request port (rom_cs/rom_addr → rom_data/rom_ok) from a shared 16-bit SDRAM-style memory channel with a req/ack + data-strobe handshake.
- Caches one 4-byte line so sequential ADPCM nibble fetches hit locally, and only misses generate memory traffic.

Parameters:
- AW, 17, byte address width of the core ROM port.
- MW, 22, word address width of the memory channel.
- BASE, 22'h0, word offset added to every memory address, locating the sample ROM in shared memory.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous, active-low reset.
- flush  in  1  invalidates all cached lines (ROM reload); single-cycle pulse.
- rom_cs  in  1  core request active.
- rom_addr  in  AW  core byte address.
- rom_data  out  8  byte returned to the core.
- rom_ok  out  1  rom_data is valid for the current rom_addr.
- mem_req  out  1  memory read request; held until acknowledged.
- mem_addr  out  MW  word address of the first word of the line.
- mem_ack  in  1  request accepted (one-cycle pulse).
- mem_dst  in  1  data strobe; one pulse per returned 16-bit word.
- mem_data  in  16  memory read data, sampled on mem_dst.

Behaviour:
- Reset (rstn=0, async):
  - rom_data=0, rom_ok=0, mem_req=0, mem_addr=0.
  - Line valid=0; FSM=IDLE.
- Line format:
  - tag = addr[AW-1:2]; data[31:0], two words.
  - Word 0 is the low half. Byte n = data[8n+7:8n], so little-endian within a word: byte0 = word0[7:0].
- Hit:
  - Condition: rom_cs & valid & tag==rom_addr[AW-1:2].
  - On a hit, register rom_data = selected byte and addr_q = rom_addr; set ok_q=1.
  - On a miss, or when rom_cs=0, ok_q=0.
  - rom_ok = ok_q & rom_cs & (rom_addr==addr_q), gated combinationally. It never flags stale data after an address change.
  - Hit latency: 1 clk.
- FSM states: IDLE, REQ, RD0, RD1.
  - IDLE→REQ: on rom_cs & miss.
    - Set valid=0; latch ftag = rom_addr[AW-1:2].
    - mem_addr = BASE + {ftag,1'b0}; assert mem_req.
  - REQ→RD0: on mem_ack; mem_req drops the next cycle.
    - mem_ack is allowed in the same cycle mem_req rises as seen by the memory.
  - RD0→RD1: on mem_dst; capture word0.
  - RD1→IDLE: on mem_dst; capture word1; tag=ftag; valid=1 unless the fetch is poisoned.
    - The hit path serves the core on the following cycle (miss-to-ok = ack latency + 2 strobes + 1).
- mem_dst outside RD0/RD1 is ignored.
- Core behaviour during a fetch:
  - rom_cs dropped mid-fetch: the burst still completes and the line is filled.
  - rom_addr changed mid-fetch: the burst completes; the hit/miss decision is re-evaluated in IDLE.
- flush:
  - Clears valid immediately.
  - If asserted during REQ/RD0/RD1, the fetch is poisoned: the burst completes (the handshake must not be abandoned), but valid stays 0. IDLE then re-requests if rom_cs is still high.
  - flush coinciding with a RD1 final strobe also poisons that fetch.
- Address arithmetic:
  - Wraps modulo 2^MW; BASE + offset overflow is discarded.
  - The tag covers the full AW-2 bits; no aliasing.

Optional Feature:
- Macro: JT7759_ROM_PREFETCH_EN.
- Defined:
  - Adds a second line buffer; both lines are hit-checked.
  - After any demand fill of line T, the FSM issues a prefetch of line T+1, modulo 2^(AW-2), so 0x7FFF wraps to 0.
  - The prefetch fills the buffer not holding T.
  - A demand miss arriving during a prefetch waits for it to complete.
  - flush poisons and invalidates both lines.
- Undefined: single line; no speculative requests. mem_req only follows demand misses.

Test Plan:
- Reset mid-fetch: drop rstn during RD0 → all outputs 0 asynchronously; the next rom_cs at 0x00004 issues mem_addr=BASE+2.
- Cold miss: rom_cs=1, rom_addr=0x00005, BASE=0, ack after 3 clk, strobes 0x2211 then 0x4433 → mem_addr=2; rom_ok with rom_data=0x22 one clk after the second strobe.
- Sequential hits: after a fill at 0x00004, step rom_addr 4,5,6,7 → rom_data 0x11,0x22,0x33,0x44; no mem_req; rom_ok low for exactly 1 clk after each address change.
- Flush during RD0: fill completes → valid stays 0; a second mem_req for the same line follows; rom_ok only after the second fill.
- Wrap: BASE=22'h3FFFFE, rom_addr=0x00008 → mem_addr=22'h000002.
- Prefetch (macro on): fill line 0x7FFF → prefetch mem_addr=BASE+0; rom_addr=0x00000 then hits with no further request.
